order_manager: RTL and testbench

Game-logic stage directly upstream of the graphics block. Owns the customer order queue, per-order countdown timers, round timer and score. Drives the `orders`, `order_times`, `time_left` and `point_total` inputs of the renderer. Consumes delivery pulses from the player/grid logic.

---
 rtl/order_manager.sv | 215 +++++++++++++++++++++
 tb/tb_order_manager.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/order_manager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | order_manager                                                            |
// | Customer order queue, per-order timers, round timer and score feeding    |
// | the renderer. Optional TIME_BONUS_EN: delivery also awards slot-0 secs.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module order_manager #(
  parameter int         MAX_ORDERS     = 4,
  parameter int         TICKS_PER_SEC  = 65000000,
  parameter int         ROUND_TIME     = 180,
  parameter int         ORDER_TIME     = 30,
  parameter int         SPAWN_INTERVAL = 20,
  parameter int         DELIVER_POINTS = 20,
  parameter int         EXPIRE_PENALTY = 10,
  parameter logic [2:0] GS_PLAY        = 3'd1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [2:0]      game_state,
  input  logic            deliver,
  output logic [3:0]      orders,
  output logic [3:0][4:0] order_times,
  output logic [7:0]      time_left,
  output logic [9:0]      point_total,
  output logic            deliver_reject,
  output logic            round_over
);

  localparam int             c_PRESC_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int             c_SPAWN_W    = $clog2(SPAWN_INTERVAL + 1);
  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [c_SPAWN_W-1:0] c_SPAWN_LAST = c_SPAWN_W'(SPAWN_INTERVAL);
  localparam logic [3:0]     c_MAX_ORDERS = 4'(MAX_ORDERS);
  localparam logic [4:0]     c_ORDER_TIME = 5'(ORDER_TIME);
  localparam logic [7:0]     c_ROUND_TIME = 8'(ROUND_TIME);
  localparam logic [9:0]     c_PENALTY    = 10'(EXPIRE_PENALTY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_PRESC_W-1:0]  r_presc;
  logic [c_SPAWN_W-1:0]  r_spawn_cnt;
  logic [3:0][4:0]       r_q;
  logic [3:0]            r_orders;
  logic [7:0]            r_time_left;
  logic [9:0]            r_points;
  logic                  r_reject;
  logic                  r_round_over;

  logic                  w_tick;
  logic [10:0]           w_gain;
  logic [3:0][4:0]       w_q;
  logic [3:0]            w_n;
  logic [9:0]            w_score;
  logic [7:0]            w_time;
  logic [c_SPAWN_W-1:0]  w_spawn_inc;
  logic [c_SPAWN_W-1:0]  w_spawn_cnt;
  logic                  w_reject;
  logic                  w_end;

  function automatic logic [3:0][4:0] f_shift(input logic [3:0][4:0] q);
    return {5'd0, q[3], q[2], q[1]};
  endfunction

  function automatic logic [9:0] f_sat_add(input logic [9:0] a, input logic [10:0] b);
    logic [10:0] s;
    s = {1'b0, a} + b;
    return s[10] ? 10'd1023 : s[9:0];
  endfunction

  function automatic logic [9:0] f_sat_sub(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? 10'd0 : a - b;
  endfunction

  // Bonus uses the oldest order's remaining seconds before this cycle's decrement.
`ifdef TIME_BONUS_EN
  assign w_gain = 11'(DELIVER_POINTS) + {6'd0, r_q[0]};
`else
  assign w_gain = 11'(DELIVER_POINTS);
`endif

  assign w_tick      = (r_presc == c_PRESC_LAST);
  assign w_spawn_inc = r_spawn_cnt + 1'b1;

  // Next queue/score for one PLAY cycle: delivery, then decrement, expiry, spawn.
  always_comb begin
    w_q         = r_q;
    w_n         = r_orders;
    w_score     = r_points;
    w_time      = r_time_left;
    w_spawn_cnt = r_spawn_cnt;
    w_reject    = 1'b0;
    w_end       = 1'b0;

    if (deliver) begin
      if (w_n != 4'd0) begin
        w_score = f_sat_add(w_score, w_gain);
        w_q     = f_shift(w_q);
        w_n     = w_n - 4'd1;
      end else begin
        w_reject = 1'b1;
      end
    end

    if (w_tick) begin
      w_time = r_time_left - 8'd1;
      w_end  = (r_time_left == 8'd1);
      for (int i = 0; i < 4; i++) begin
        if (4'(i) < w_n) begin
          w_q[i] = w_q[i] - 5'd1;
        end
      end

      if ((w_n != 4'd0) && (w_q[0] == 5'd0)) begin
        w_q     = f_shift(w_q);
        w_n     = w_n - 4'd1;
        w_score = f_sat_sub(w_score, c_PENALTY);
      end

      if (w_spawn_inc == c_SPAWN_LAST) begin
        w_spawn_cnt = '0;
        if (w_n < c_MAX_ORDERS) begin
          for (int i = 0; i < 4; i++) begin
            if (w_n == 4'(i)) begin
              w_q[i] = c_ORDER_TIME;
            end
          end
          w_n = w_n + 4'd1;
        end
      end else begin
        w_spawn_cnt = w_spawn_inc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_spawn_cnt  <= '0;
      r_q          <= '0;
      r_orders     <= 4'd0;
      r_time_left  <= 8'd0;
      r_points     <= 10'd0;
      r_reject     <= 1'b0;
      r_round_over <= 1'b0;
    end else begin
      r_reject     <= 1'b0;
      r_round_over <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (game_state == GS_PLAY) begin
            r_state     <= S_PLAY;
            r_time_left <= c_ROUND_TIME;
            r_points    <= 10'd0;
            r_q         <= {15'd0, c_ORDER_TIME};
            r_orders    <= 4'd1;
            r_presc     <= '0;
            r_spawn_cnt <= '0;
          end else begin
            r_q      <= '0;
            r_orders <= 4'd0;
          end
        end

        S_PLAY: begin
          if (game_state != GS_PLAY) begin
            r_state  <= S_IDLE;
            r_q      <= '0;
            r_orders <= 4'd0;
          end else begin
            r_presc     <= w_tick ? '0 : r_presc + 1'b1;
            r_spawn_cnt <= w_spawn_cnt;
            r_time_left <= w_time;
            r_points    <= w_score;
            r_reject    <= w_reject;
            if (w_end) begin
              r_state      <= S_OVER;
              r_round_over <= 1'b1;
              r_q          <= '0;
              r_orders     <= 4'd0;
            end else begin
              r_q      <= w_q;
              r_orders <= w_n;
            end
          end
        end

        S_OVER: begin
          if (game_state != GS_PLAY) begin
            r_state  <= S_IDLE;
            r_q      <= '0;
            r_orders <= 4'd0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign orders         = r_orders;
  assign order_times    = r_q;
  assign time_left      = r_time_left;
  assign point_total    = r_points;
  assign deliver_reject = r_reject;
  assign round_over     = r_round_over;

endmodule
`default_nettype wire

// File: tb/tb_order_manager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_order_manager                                                         |
// | Directed bench for order_manager with 4 clocks per game second and a     |
// | 3-second spawn interval so the queue fills, drops spawns and saturates.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_order_manager;

  localparam int c_TPS = 4;
`ifdef TIME_BONUS_EN
  localparam int c_BONUS = 1;
`else
  localparam int c_BONUS = 0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [2:0]      game_state = 3'd0;
  logic            deliver = 1'b0;
  logic [3:0]      orders;
  logic [3:0][4:0] order_times;
  logic [7:0]      time_left;
  logic [9:0]      point_total;
  logic            deliver_reject;
  logic            round_over;

  int checks = 0;
  int errors = 0;
  int exp_pts = 0;

  order_manager #(
    .TICKS_PER_SEC (c_TPS),
    .SPAWN_INTERVAL(3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .game_state    (game_state),
    .deliver       (deliver),
    .orders        (orders),
    .order_times   (order_times),
    .time_left     (time_left),
    .point_total   (point_total),
    .deliver_reject(deliver_reject),
    .round_over    (round_over)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pack(input int s0, input int s1, input int s2, input int s3);
    logic [4:0] a, b, c, d;
    a = 5'(s0); b = 5'(s1); c = 5'(s2); d = 5'(s3);
    return int'({d, c, b, a});
  endfunction

  function automatic int add_pts(input int s, input int slot0);
    int t;
    t = s + 20 + c_BONUS * slot0;
    return (t > 1023) ? 1023 : t;
  endfunction

  function automatic int sub_pts(input int s);
    return (s < 10) ? 0 : s - 10;
  endfunction

  // One clock edge with the given deliver level; returns 1 ns after the edge.
  task automatic step(input logic d);
    deliver = d;
    @(posedge clock);
    #1;
    deliver = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic run_secs(input int n);
    idle(n * c_TPS);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_orders", int'(orders), 0);
    check("rst_times", int'(order_times), 0);
    check("rst_time_left", int'(time_left), 0);
    check("rst_points", int'(point_total), 0);
    check("rst_reject", int'(deliver_reject), 0);
    check("rst_round_over", int'(round_over), 0);

    reset = 1'b1;
    step(1'b1);
    check("idle_deliver_ignored", int'(deliver_reject), 0);

    // Round 1 entry edge is t0, phase 0.
    game_state = 3'd1;
    step(1'b0);
    check("entry_orders", int'(orders), 1);
    check("entry_times", int'(order_times), pack(30, 0, 0, 0));
    check("entry_time_left", int'(time_left), 180);
    check("entry_points", int'(point_total), 0);

    run_secs(3);
    check("t3_orders", int'(orders), 2);
    check("t3_times", int'(order_times), pack(27, 30, 0, 0));
    check("t3_time_left", int'(time_left), 177);

    run_secs(6);
    check("t9_orders", int'(orders), 4);
    check("t9_times", int'(order_times), pack(21, 24, 27, 30));

    run_secs(3);
    check("t12_dropped_orders", int'(orders), 4);
    check("t12_times", int'(order_times), pack(18, 21, 24, 27));

    run_secs(18);
    check("t30_expire_orders", int'(orders), 4);
    check("t30_times", int'(order_times), pack(3, 6, 9, 30));
    check("t30_floor_points", int'(point_total), 0);
    check("t30_time_left", int'(time_left), 150);

    step(1'b1);
    exp_pts = add_pts(exp_pts, 3);
    check("dlv1_points", int'(point_total), exp_pts);
    check("dlv1_times", int'(order_times), pack(6, 9, 30, 0));
    step(1'b1);
    exp_pts = add_pts(exp_pts, 6);
    check("dlv2_orders", int'(orders), 2);
    check("dlv2_times", int'(order_times), pack(9, 30, 0, 0));
    check("dlv2_points", int'(point_total), exp_pts);
    step(1'b0);
    step(1'b0);
    check("t31_times", int'(order_times), pack(8, 29, 0, 0));
    step(1'b1);
    exp_pts = add_pts(exp_pts, 8);
    step(1'b1);
    exp_pts = add_pts(exp_pts, 29);
    check("dlv4_orders", int'(orders), 0);
    check("dlv4_points", int'(point_total), exp_pts);
    step(1'b1);
    check("reject_pulse", int'(deliver_reject), 1);
    check("reject_points", int'(point_total), exp_pts);
    check("reject_orders", int'(orders), 0);
    step(1'b0);
    check("reject_clears", int'(deliver_reject), 0);
    check("t32_time_left", int'(time_left), 148);

    run_secs(30);
    check("t62_orders", int'(orders), 4);
    check("t62_times", int'(order_times), pack(1, 4, 7, 10));
    idle(3);
    step(1'b1);
    exp_pts = add_pts(exp_pts, 1);
    check("tick_dlv_points", int'(point_total), exp_pts);
    check("tick_dlv_orders", int'(orders), 4);
    check("tick_dlv_times", int'(order_times), pack(3, 6, 9, 30));

    // Fifteen expiries between t64 and t179.
    run_secs(116);
    for (int i = 0; i < 15; i++) exp_pts = sub_pts(exp_pts);
    check("t179_points", int'(point_total), exp_pts);
    check("t179_times", int'(order_times), pack(4, 7, 10, 13));
    check("t179_time_left", int'(time_left), 1);
    step(1'b1);
    exp_pts = add_pts(exp_pts, 4);
    step(1'b1);
    exp_pts = add_pts(exp_pts, 7);
    check("t179_dlv_times", int'(order_times), pack(10, 13, 0, 0));
    step(1'b0);
    step(1'b0);
    check("over_pulse", int'(round_over), 1);
    check("over_orders", int'(orders), 0);
    check("over_times", int'(order_times), 0);
    check("over_time_left", int'(time_left), 0);
    check("over_points", int'(point_total), exp_pts);
    step(1'b1);
    check("over_pulse_single", int'(round_over), 0);
    check("over_deliver_ignored", int'(deliver_reject), 0);
    check("over_points_held", int'(point_total), exp_pts);

    game_state = 3'd0;
    step(1'b0);
    check("idle_orders", int'(orders), 0);
    check("idle_points_held", int'(point_total), exp_pts);
    check("idle_time_left_held", int'(time_left), 0);

    game_state = 3'd1;
    step(1'b0);
    exp_pts = 0;
    check("r2_orders", int'(orders), 1);
    check("r2_times", int'(order_times), pack(30, 0, 0, 0));
    check("r2_time_left", int'(time_left), 180);
    check("r2_points", int'(point_total), 0);

    // Deliver each fresh order the cycle after it spawns.
    for (int k = 0; k < 50; k++) begin
      step(1'b1);
      exp_pts = add_pts(exp_pts, 30);
      idle(11);
    end
    check("r2_t150_points", int'(point_total), exp_pts);
    check("r2_t150_orders", int'(orders), 1);
    step(1'b1);
    exp_pts = add_pts(exp_pts, 30);
    idle(11);
    step(1'b1);
    exp_pts = add_pts(exp_pts, 30);
    check("sat_points", int'(point_total), exp_pts);
    check("sat_is_max", int'(point_total), 1023);
    idle(11);
    step(1'b1);
    check("sat_hold", int'(point_total), 1023);
    check("r2_orders_empty", int'(orders), 0);
    check("r2_time_left", int'(time_left), 24);

    #2;
    reset = 1'b0;
    #1;
    check("async_orders", int'(orders), 0);
    check("async_times", int'(order_times), 0);
    check("async_time_left", int'(time_left), 0);
    check("async_points", int'(point_total), 0);
    check("async_reject", int'(deliver_reject), 0);
    check("async_round_over", int'(round_over), 0);
    idle(2);
    reset = 1'b1;
    step(1'b0);
    check("post_rst_orders", int'(orders), 1);
    check("post_rst_time_left", int'(time_left), 180);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
